// File: rtl/imem_load_pkg.sv
// Shared types and default sizing for the instruction-memory loader.
package imem_load_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/imem_port_mux.sv
// Chooses who drives the single-port instruction memory: the loader during LOAD,
// the CPU fetch port during RUN, nobody while IDLE.
module imem_port_mux
    import imem_load_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  state_t            i_state,
    input  logic              i_ldValid,
    input  logic [ADDR_W-1:0] i_tbAddr,
    input  logic [DATA_W-1:0] i_ldData,
    input  logic              i_cpuReq,
    input  logic [ADDR_W-1:0] i_cpuAddr,
    output logic              o_memEn,
    output logic              o_memWe,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memWdata
);

    always_comb begin
        o_memEn    = 1'b0;
        o_memWe    = 1'b0;
        o_memAddr  = '0;
        o_memWdata = '0;
        case (i_state)
            LOAD: begin
                o_memEn    = i_ldValid;
                o_memWe    = i_ldValid;
                o_memAddr  = i_tbAddr;
                o_memWdata = i_ldData;
            end
            RUN: begin
                o_memEn   = i_cpuReq;
                o_memAddr = i_cpuAddr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory program loader: streams load_len words into IMEM, then releases the CPU.
// Define IMEM_LOAD_CHECKSUM_EN to get a running sum of the loaded words on 'checksum'.
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] tb_addr,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_lastAddr;
    logic              r_err;
    logic              r_rvalid;
    logic              w_lenOk;
    logic              w_canStart;
    logic              w_startOk;
    logic              w_startBad;
    logic              w_accept;
    logic              w_lastWord;

    // A load request is only honoured outside LOAD; the length must fit the memory.
    assign w_lenOk    = (load_len != '0) && (load_len <= MAX_LEN);
    assign w_canStart = (r_state != LOAD);
    assign w_startOk  = load_start && w_lenOk && w_canStart;
    assign w_startBad = load_start && !w_lenOk && w_canStart;
    assign w_accept   = (r_state == LOAD) && ld_valid;
    assign w_lastWord = w_accept && (r_addr == r_lastAddr);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_startOk)  w_nextState = LOAD;
            LOAD:    if (w_lastWord) w_nextState = RUN;
            RUN:     if (w_startOk)  w_nextState = LOAD;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The address holds at the last written location so it only wraps on a reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_lastAddr <= '0;
        end else if (w_startOk) begin
            r_addr     <= '0;
            r_lastAddr <= ADDR_W'(load_len - (ADDR_W+1)'(1));
        end else if (w_accept && !w_lastWord) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_startOk) begin
            r_err <= 1'b0;
        end else if (w_startBad) begin
            r_err <= 1'b1;
        end
    end

    // A fetch issued in the same cycle as a reload never reports back to the CPU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= (r_state == RUN) && cpu_req && !w_startOk;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (w_startOk) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + ld_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    imem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_portMux (
        .i_state    (r_state),
        .i_ldValid  (ld_valid),
        .i_tbAddr   (r_addr),
        .i_ldData   (ld_data),
        .i_cpuReq   (cpu_req),
        .i_cpuAddr  (cpu_addr),
        .o_memEn    (mem_en),
        .o_memWe    (mem_we),
        .o_memAddr  (mem_addr),
        .o_memWdata (mem_wdata)
    );

    assign ld_ready   = (r_state == LOAD);
    assign busy       = (r_state == LOAD);
    assign done       = (r_state == RUN);
    assign cpu_rst_n  = (r_state == RUN);
    assign tb_addr    = r_addr;
    assign err        = r_err;
    assign cpu_rvalid = r_rvalid;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed, table-driven bench for imem_load_ctrl with a behavioural 1-cycle-latency memory.
module tb_imem_load_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              reset_n;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W-1:0] tb_addr;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] memRdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] checksum;

    logic [DATA_W-1:0] memArr [0:DEPTH-1];
    int                wrCount = 0;
    logic [ADDR_W-1:0] lastWrAddr = '0;
    int                errCnt = 0;
    int                chkCnt = 0;

    typedef struct {
        logic              ls;
        logic [ADDR_W:0]   len;
        logic              lv;
        logic [DATA_W-1:0] ldata;
        logic              creq;
        logic [ADDR_W-1:0] caddr;
        logic              eBusy;
        logic              eDone;
        logic              eCrst;
        logic              eErr;
        logic              eRvalid;
        logic [ADDR_W-1:0] eAddr;
        logic [DATA_W-1:0] eRdata;
    } vec_t;

    vec_t vecQ[$];

    imem_load_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .load_len   (load_len),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .tb_addr    (tb_addr),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (memRdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory model with registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                memArr[mem_addr] <= mem_wdata;
                wrCount          <= wrCount + 1;
                lastWrAddr       <= mem_addr;
            end else begin
                memRdata <= memArr[mem_addr];
            end
        end
    end

    task automatic checkVal(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic ls, input logic [ADDR_W:0] len, input logic lv,
                          input logic [DATA_W-1:0] ldata, input logic creq, input logic [ADDR_W-1:0] caddr,
                          input logic eBusy, input logic eDone, input logic eCrst, input logic eErr,
                          input logic eRvalid, input logic [ADDR_W-1:0] eAddr, input logic [DATA_W-1:0] eRdata);
        vec_t v;
        v.ls = ls; v.len = len; v.lv = lv; v.ldata = ldata; v.creq = creq; v.caddr = caddr;
        v.eBusy = eBusy; v.eDone = eDone; v.eCrst = eCrst; v.eErr = eErr;
        v.eRvalid = eRvalid; v.eAddr = eAddr; v.eRdata = eRdata;
        vecQ.push_back(v);
    endtask

    task automatic idleInputs();
        load_start = 1'b0;
        load_len   = '0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
    endtask

    // Called at a falling edge: drive one cycle of inputs, then sample after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        load_start = v.ls;
        load_len   = v.len;
        ld_valid   = v.lv;
        ld_data    = v.ldata;
        cpu_req    = v.creq;
        cpu_addr   = v.caddr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("vec%0d busy", idx), busy, v.eBusy);
        checkVal($sformatf("vec%0d ld_ready", idx), ld_ready, v.eBusy);
        checkVal($sformatf("vec%0d done", idx), done, v.eDone);
        checkVal($sformatf("vec%0d cpu_rst_n", idx), cpu_rst_n, v.eCrst);
        checkVal($sformatf("vec%0d err", idx), err, v.eErr);
        checkVal($sformatf("vec%0d cpu_rvalid", idx), cpu_rvalid, v.eRvalid);
        checkVal($sformatf("vec%0d tb_addr", idx), tb_addr, v.eAddr);
        if (v.eRvalid) begin
            checkVal($sformatf("vec%0d cpu_rdata", idx), cpu_rdata, v.eRdata);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, " busy"}, busy, 1'b0);
        checkVal({tag, " done"}, done, 1'b0);
        checkVal({tag, " err"}, err, 1'b0);
        checkVal({tag, " cpu_rst_n"}, cpu_rst_n, 1'b0);
        checkVal({tag, " ld_ready"}, ld_ready, 1'b0);
        checkVal({tag, " mem_en"}, mem_en, 1'b0);
        checkVal({tag, " mem_we"}, mem_we, 1'b0);
        checkVal({tag, " cpu_rvalid"}, cpu_rvalid, 1'b0);
        checkVal({tag, " tb_addr"}, tb_addr, '0);
        checkVal({tag, " checksum"}, checksum, '0);
    endtask

    initial begin
        int wrBase;
        logic [DATA_W-1:0] expSum;

        reset_n = 1'b0;
        idleInputs();
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        //     ls len      lv data          req addr | busy done crst err rv addr rdata
        addVec(0, 11'd0,    0, 32'h0,        0, 10'd0,  0, 0, 0, 0, 0, 10'd0, 32'h0);
        addVec(1, 11'd0,    1, 32'hBAD0BAD0, 0, 10'd0,  0, 0, 0, 1, 0, 10'd0, 32'h0);
        addVec(1, 11'd1025, 1, 32'hBAD0BAD0, 0, 10'd0,  0, 0, 0, 1, 0, 10'd0, 32'h0);
        addVec(1, 11'd4,    0, 32'h0,        0, 10'd0,  1, 0, 0, 0, 0, 10'd0, 32'h0);
        addVec(0, 11'd0,    1, 32'h00500093, 0, 10'd0,  1, 0, 0, 0, 0, 10'd1, 32'h0);
        addVec(0, 11'd0,    1, 32'h00A00113, 0, 10'd0,  1, 0, 0, 0, 0, 10'd2, 32'h0);
        addVec(0, 11'd0,    1, 32'h002081B3, 0, 10'd0,  1, 0, 0, 0, 0, 10'd3, 32'h0);
        addVec(0, 11'd0,    1, 32'h00000013, 0, 10'd0,  0, 1, 1, 0, 0, 10'd3, 32'h0);
        addVec(0, 11'd0,    1, 32'hDEADBEEF, 1, 10'd2,  0, 1, 1, 0, 1, 10'd3, 32'h002081B3);
        addVec(0, 11'd0,    0, 32'h0,        0, 10'd0,  0, 1, 1, 0, 0, 10'd3, 32'h0);
        addVec(0, 11'd0,    0, 32'h0,        1, 10'd0,  0, 1, 1, 0, 1, 10'd3, 32'h00500093);
        addVec(1, 11'd3,    0, 32'h0,        1, 10'd3,  1, 0, 0, 0, 0, 10'd0, 32'h0);
        addVec(0, 11'd0,    1, 32'h11111111, 0, 10'd0,  1, 0, 0, 0, 0, 10'd1, 32'h0);
        addVec(0, 11'd0,    0, 32'h0,        0, 10'd0,  1, 0, 0, 0, 0, 10'd1, 32'h0);
        addVec(0, 11'd0,    0, 32'h0,        0, 10'd0,  1, 0, 0, 0, 0, 10'd1, 32'h0);
        addVec(0, 11'd0,    1, 32'h22222222, 0, 10'd0,  1, 0, 0, 0, 0, 10'd2, 32'h0);
        addVec(0, 11'd0,    0, 32'h0,        0, 10'd0,  1, 0, 0, 0, 0, 10'd2, 32'h0);
        addVec(0, 11'd0,    1, 32'h33333333, 0, 10'd0,  0, 1, 1, 0, 0, 10'd2, 32'h0);

        for (int i = 0; i < vecQ.size(); i++) begin
            applyStimulus(vecQ[i]);
            checkOutput(vecQ[i], i);
        end
        idleInputs();

        checkVal("table write count", wrCount, 7);
        checkVal("mem[0] after reload", memArr[0], 32'h11111111);
        checkVal("mem[1] after reload", memArr[1], 32'h22222222);
        checkVal("mem[2] after reload", memArr[2], 32'h33333333);
        checkVal("mem[3] untouched", memArr[3], 32'h00000013);

        // Reset in the middle of a load after two accepted words.
        load_start = 1'b1;
        load_len   = 11'd4;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        ld_valid   = 1'b1;
        ld_data    = 32'hAAAA0001;
        @(posedge clk);
        @(negedge clk);
        ld_data = 32'hAAAA0002;
        @(posedge clk);
        @(negedge clk);
        ld_data = 32'hAAAA0003;
        checkVal("midload busy", busy, 1'b1);
        checkVal("midload tb_addr", tb_addr, 10'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("async reset");
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        checkVal("post-reset cpu_rst_n", cpu_rst_n, 1'b0);
        checkVal("post-reset busy", busy, 1'b0);
        checkVal("abandoned mem[0]", memArr[0], 32'hAAAA0001);
        checkVal("abandoned mem[1]", memArr[1], 32'hAAAA0002);
        checkVal("abandoned mem[2]", memArr[2], 32'h33333333);

        load_start = 1'b1;
        load_len   = 11'd1;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        ld_valid   = 1'b1;
        ld_data    = 32'hCAFEF00D;
        checkVal("len1 busy", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        checkVal("len1 done", done, 1'b1);
        checkVal("len1 cpu_rst_n", cpu_rst_n, 1'b1);
        checkVal("len1 busy", busy, 1'b0);
        checkVal("len1 mem[0]", memArr[0], 32'hCAFEF00D);

        // Full-depth load: last write must land on the top address.
        load_start = 1'b1;
        load_len   = 11'd1024;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        wrBase = wrCount;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h5A5A0000 | 32'(i);
            if (i == DEPTH - 1) begin
                checkVal("full tb_addr before last", tb_addr, 10'd1023);
                checkVal("full busy before last", busy, 1'b1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        checkVal("full done", done, 1'b1);
        checkVal("full busy", busy, 1'b0);
        checkVal("full tb_addr held", tb_addr, 10'd1023);
        checkVal("full write count", wrCount - wrBase, DEPTH);
        checkVal("full last write addr", lastWrAddr, 10'd1023);
        checkVal("full mem[0]", memArr[0], 32'h5A5A0000);
        checkVal("full mem[1023]", memArr[1023], 32'h5A5A03FF);

        // Checksum wraps modulo 2^32.
        load_start = 1'b1;
        load_len   = 11'd2;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        ld_valid   = 1'b1;
        ld_data    = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        ld_data = 32'h00000002;
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        expSum = 32'h00000001;
`else
        expSum = 32'h00000000;
`endif
        checkVal("checksum done", done, 1'b1);
        checkVal("checksum value", checksum, expSum);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
